// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the decoded-key outputs handed to the lock-entry FSM.
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       newKey;
  logic [4:0] keyCode;
  logic       keyDown;

  modport master (input rows, output cols, output newKey, output keyCode, output keyDown);
  modport slave  (output rows, input cols, input newKey, input keyCode, input keyDown);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scan with 2-flop row sync and debounce; one newKey pulse per accepted press.
// Pulse is registered, one cycle after the DB_SCANS-th matching scan; no backpressure, every pulse must be taken.
module keypad_scanner #(
  parameter int SETTLE_CYC = 4,
  parameter int DB_SCANS   = 4
) (
  input  logic              clk5,
  input  logic              reset,
  keypad_scanner_if.master  kp
);

  localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int CNW = $clog2(DB_SCANS + 1);
  localparam logic [SCW-1:0] SET_LAST = SCW'(SETTLE_CYC - 1);
  localparam logic [CNW-1:0] CNT_ONE  = CNW'(1);
  localparam logic [CNW-1:0] CNT_DONE = CNW'(DB_SCANS);

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

  logic [3:0]     sync1_q, sync1_d, sync2_q, sync2_d;
  logic [SCW-1:0] set_cnt_q, set_cnt_d;
  logic [1:0]     col_q, col_d;
  logic [15:0]    samp_q, samp_d;
  state_t         state_q, state_d;
  logic [CNW-1:0] cnt_q, cnt_d;
  logic [3:0]     cand_q, cand_d;
  logic           new_key_q, new_key_d;
  logic [4:0]     key_code_q, key_code_d;

  logic           last_cyc, scan_done, accept;
  logic [4:0]     low_cnt;
  logic [3:0]     key_idx;
  logic           is_none, is_one;

  // Sample index is col*4 + row.
  function automatic logic [4:0] code_of(input logic [3:0] idx);
    case (idx)
      4'd0:  code_of = 5'b10001; // 1
      4'd1:  code_of = 5'b10100; // 4
      4'd2:  code_of = 5'b10111; // 7
      4'd3:  code_of = 5'b11110; // * (ENTER)
      4'd4:  code_of = 5'b10010; // 2
      4'd5:  code_of = 5'b10101; // 5
      4'd6:  code_of = 5'b11000; // 8
      4'd7:  code_of = 5'b10000; // 0
      4'd8:  code_of = 5'b10011; // 3
      4'd9:  code_of = 5'b10110; // 6
      4'd10: code_of = 5'b11001; // 9
      4'd11: code_of = 5'b11111; // #
      4'd12: code_of = 5'b11010; // A
      4'd13: code_of = 5'b11011; // B
      4'd14: code_of = 5'b11100; // C (CLEAR)
      default: code_of = 5'b11101; // D
    endcase
  endfunction

  always_comb begin
    sync1_d   = kp.rows;
    sync2_d   = sync1_q;
    last_cyc  = (set_cnt_q == SET_LAST);
    scan_done = last_cyc && (col_q == 2'd3);
    set_cnt_d = last_cyc ? '0 : set_cnt_q + SCW'(1);
    col_d     = last_cyc ? col_q + 2'd1 : col_q;
    samp_d    = samp_q;
    if (last_cyc) begin
      case (col_q)
        2'd0:    samp_d[3:0]   = ~sync2_q;
        2'd1:    samp_d[7:4]   = ~sync2_q;
        2'd2:    samp_d[11:8]  = ~sync2_q;
        default: samp_d[15:12] = ~sync2_q;
      endcase
    end
  end

  // Classification reads samp_d so column 3's sample taken this cycle is included.
  always_comb begin
    low_cnt = '0;
    key_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (samp_d[i]) begin
        low_cnt = low_cnt + 5'd1;
        key_idx = 4'(i);
      end
    end
    is_none = (low_cnt == 5'd0);
    is_one  = (low_cnt == 5'd1);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    accept     = 1'b0;
    if (scan_done) begin
      case (state_q)
        S_IDLE: begin
          if (is_one) begin
            cand_d = key_idx;
            cnt_d  = CNT_ONE;
            if (CNT_ONE == CNT_DONE) begin
              accept  = 1'b1;
              state_d = S_PRESSED;
            end else begin
              state_d = S_DEBOUNCE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (is_one && (key_idx == cand_q)) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_d == CNT_DONE) begin
              accept  = 1'b1;
              state_d = S_PRESSED;
            end
          end else if (is_one) begin
            cand_d = key_idx;
            cnt_d  = CNT_ONE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PRESSED: begin
          if (is_none) begin
            cnt_d   = CNT_ONE;
            state_d = (CNT_ONE == CNT_DONE) ? S_IDLE : S_RELEASE;
          end
        end
        default: begin
          if (is_none) begin
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_d == CNT_DONE) state_d = S_IDLE;
          end else begin
            state_d = S_PRESSED;
          end
        end
      endcase
    end
    new_key_d  = accept;
    key_code_d = accept ? code_of(cand_d) : key_code_q;
  end

  always_ff @(posedge clk5) begin
    if (reset) begin
      sync1_q    <= 4'hF;
      sync2_q    <= 4'hF;
      set_cnt_q  <= '0;
      col_q      <= 2'd0;
      samp_q     <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cand_q     <= '0;
      new_key_q  <= 1'b0;
      key_code_q <= 5'b00000;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      set_cnt_q  <= set_cnt_d;
      col_q      <= col_d;
      samp_q     <= samp_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      new_key_q  <= new_key_d;
      key_code_q <= key_code_d;
    end
  end

  assign kp.cols    = ~(4'b0001 << col_q);
  assign kp.newKey  = new_key_q;
  assign kp.keyCode = key_code_q;
  assign kp.keyDown = (state_q == S_PRESSED) || (state_q == S_RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed keypad bench: a matrix model drives rows, a scoreboard checks every newKey pulse.
module tb_keypad_scanner;

  logic clk5 = 1'b0;
  logic reset;
  always #5 clk5 = ~clk5;

  keypad_scanner_if kp();

  keypad_scanner #(.SETTLE_CYC(4), .DB_SCANS(4)) dut (
    .clk5  (clk5),
    .reset (reset),
    .kp    (kp)
  );

  // pressed index is row*4 + col
  logic [15:0] pressed;
  logic [3:0]  row_l;
  always_comb begin
    row_l = 4'hF;
    for (int r = 0; r < 4; r++) row_l[r] = ~|(pressed[r*4 +: 4] & ~kp.cols);
  end
  assign kp.rows = row_l;

  // Cycles since reset released; cycle n sits at scan position n%16.
  int cyc;
  always @(posedge clk5) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  typedef struct {
    logic [4:0] code;
    int         due;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input logic [4:0] code, input int due);
    exp_t e;
    e.code = code;
    e.due  = due;
    exp_q.push_back(e);
  endtask

  task automatic wait_scan_start();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 16 && !hit; i++) begin
      @(negedge clk5);
      if (cyc % 16 == 0) hit = 1'b1;
    end
    chk("scan_align", {31'd0, hit}, 32'd1);
  endtask

  // Scoreboard monitor
  logic prev_nk = 1'b0;
  always @(negedge clk5) begin
    if (prev_nk) begin
      checks++;
      if (kp.newKey !== 1'b0) begin
        errors++;
        $display("FAIL pulse_width newKey still high at cyc %0d, required low", cyc);
      end
    end
    if (!reset && kp.newKey === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse code=%b at cyc %0d, required no pulse", kp.keyCode, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (kp.keyCode !== e.code || (e.due >= 0 && cyc != e.due)) begin
          errors++;
          $display("FAIL pulse code=%b cyc=%0d required code=%b cyc=%0d", kp.keyCode, cyc, e.code, e.due);
        end
      end
    end
    prev_nk <= kp.newKey;
  end

  typedef struct {
    int         idx;
    logic [4:0] code;
  } key_t;
  key_t seq[6];

  initial begin
    int bad, base, rel;
    logic [3:0] exp_cols;

    reset   = 1'b1;
    pressed = '0;
    repeat (3) @(posedge clk5);
    @(negedge clk5);
    chk("rst_cols",    {28'd0, kp.cols},    32'hE);
    chk("rst_newKey",  {31'd0, kp.newKey},  32'd0);
    chk("rst_keyCode", {27'd0, kp.keyCode}, 32'd0);
    chk("rst_keyDown", {31'd0, kp.keyDown}, 32'd0);
    reset = 1'b0;

    // Idle scanning
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk5);
      exp_cols = ~(4'b0001 << ((cyc / 4) % 4));
      if (kp.cols !== exp_cols) bad++;
    end
    chk("idle_cols_bad_cycles", bad, 0);
    chk("idle_keyCode", {27'd0, kp.keyCode}, 32'd0);
    chk("idle_keyDown", {31'd0, kp.keyDown}, 32'd0);

    // Key '1' with latency and release timing
    wait_scan_start();
    base = cyc;
    pressed[0] = 1'b1;
    push_exp(5'b10001, base + 15 + 49);
    repeat (400) @(negedge clk5);
    wait_scan_start();
    rel = cyc;
    chk("held_keyDown", {31'd0, kp.keyDown}, 32'd1);
    pressed = '0;
    while (cyc < rel + 63) @(negedge clk5);
    chk("release_keyDown_before", {31'd0, kp.keyDown}, 32'd1);
    @(negedge clk5);
    chk("release_keyDown_after", {31'd0, kp.keyDown}, 32'd0);
    repeat (100) @(negedge clk5);

    // Sequence 1,2,3,4,*,C
    seq[0] = '{0,  5'b10001};
    seq[1] = '{1,  5'b10010};
    seq[2] = '{2,  5'b10011};
    seq[3] = '{4,  5'b10100};
    seq[4] = '{12, 5'b11110};
    seq[5] = '{11, 5'b11100};
    for (int k = 0; k < 6; k++) begin
      wait_scan_start();
      pressed[seq[k].idx] = 1'b1;
      push_exp(seq[k].code, -1);
      repeat (300) @(negedge clk5);
      pressed = '0;
      repeat (300) @(negedge clk5);
    end

    // Bounce on '5', then hold
    for (int i = 0; i < 20; i++) begin
      pressed[5] = ~pressed[5];
      repeat (10) @(negedge clk5);
    end
    pressed[5] = 1'b1;
    push_exp(5'b10101, -1);
    repeat (300) @(negedge clk5);
    pressed = '0;
    repeat (300) @(negedge clk5);

    // '2' and '6' together, then drop '6'
    pressed[1] = 1'b1;
    pressed[6] = 1'b1;
    repeat (400) @(negedge clk5);
    pressed[6] = 1'b0;
    push_exp(5'b10010, -1);
    repeat (300) @(negedge clk5);
    pressed = '0;
    repeat (300) @(negedge clk5);

    // Reset during debounce with '9' held
    wait_scan_start();
    base = cyc;
    pressed[10] = 1'b1;
    while (cyc < base + 35) @(negedge clk5);
    reset = 1'b1;
    @(negedge clk5);
    chk("midrst_cols",    {28'd0, kp.cols},    32'hE);
    chk("midrst_newKey",  {31'd0, kp.newKey},  32'd0);
    chk("midrst_keyDown", {31'd0, kp.keyDown}, 32'd0);
    repeat (2) @(negedge clk5);
    push_exp(5'b11001, 15 + 49);
    reset = 1'b0;
    repeat (300) @(negedge clk5);
    pressed = '0;
    repeat (300) @(negedge clk5);

    chk("pending_expected", exp_q.size(), 0);
    chk("final_keyCode", {27'd0, kp.keyCode}, 32'h19);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
